// File: rtl/trig_capture_if.sv
`default_nettype none
// ============================================================================
//  Module      : trig_capture_if
//  Description : Bus bundle between the trigger-capture buffer and its host.
//                The master drives the sample stream, the trigger level, the
//                arm/abort controls and the read index. The slave returns the
//                read data, the status flags and the trigger address.
//  Ports       : ain, trg, arm, abort, pretrig, rd_addr   (master -> slave)
//                rd_data, busy, done, trg_addr            (slave  -> master)
//  Revision    : 1.0  initial release
// ============================================================================
interface trig_capture_if #(
  parameter int DEPTH_LOG2 = 10
);
  logic [13:0]           ain;       // signed ADC sample, two's complement
  logic                  trg;
  logic                  arm;
  logic                  abort;
  logic [DEPTH_LOG2-1:0] pretrig;
  logic [DEPTH_LOG2-1:0] rd_addr;
  logic [13:0]           rd_data;
  logic                  busy;
  logic                  done;
  logic [DEPTH_LOG2-1:0] trg_addr;

  modport master (
    output ain, trg, arm, abort, pretrig, rd_addr,
    input  rd_data, busy, done, trg_addr
  );

  modport slave (
    input  ain, trg, arm, abort, pretrig, rd_addr,
    output rd_data, busy, done, trg_addr
  );
endinterface
`default_nettype wire

// File: rtl/trig_capture.sv
`default_nettype none
// ============================================================================
//  Module      : trig_capture
//  Description : Post-trigger acquisition buffer. Once armed it records the
//                (latency-aligned) ADC stream into a circular RAM, waits for a
//                rising edge of the detector's trigger level, then keeps
//                recording until exactly DEPTH samples surround the trigger:
//                pretrig before it, the trigger sample, the rest after it.
//                The frozen window is read back by logical index.
//  Ports       : clk      sample clock, rising edge
//                rst      asynchronous active-high reset
//                bus      trig_capture_if.slave (stream, control, readout)
//  Parameters  : DEPTH_LOG2  log2 of the buffer depth
//                ALIGN       ain delay matching the detector latency
//  Revision    : 1.0  initial release
// ============================================================================
module trig_capture #(
  parameter int DEPTH_LOG2 = 10,
  parameter int ALIGN      = 2
) (
  input  logic            clk,
  input  logic            rst,
  trig_capture_if.slave   bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int DW    = 14;

  typedef logic [DEPTH_LOG2-1:0] addr_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t          state_q, state_d;
  addr_t           wp_q, wp_d;
  addr_t           cnt_q, cnt_d;
  addr_t           pt_q, pt_d;
  addr_t           trg_addr_q, trg_addr_d;
  logic            trg_q, trg_d;
  logic [DW-1:0]   rd_data_q;

  logic            wr_en;
  logic            trg_event;
  logic [DW-1:0]   ain_dly;     // ain after the ALIGN-stage chain
  addr_t           rd_phys;

  logic [DW-1:0]   mem [DEPTH];

  // --------------------------------------------------------------------------
  // Sample delay chain: lines the stored sample up with the detector output so
  // the sample written on the event cycle is the one that crossed threshold.
  // --------------------------------------------------------------------------
  if (ALIGN == 0) begin : g_align_bypass
    assign ain_dly = bus.ain;
  end else begin : g_align_chain
    logic [DW-1:0] sr_q [ALIGN];
    logic [DW-1:0] sr_d [ALIGN];

    always_comb begin
      sr_d[0] = bus.ain;
      for (int i = 1; i < ALIGN; i++) begin
        sr_d[i] = sr_q[i-1];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < ALIGN; i++) begin
          sr_q[i] <= '0;
        end
      end else begin
        sr_q <= sr_d;
      end
    end

    assign ain_dly = sr_q[ALIGN-1];
  end

  assign trg_event = bus.trg & ~trg_q;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pt_d       = pt_q;
    trg_addr_d = trg_addr_q;
    trg_d      = bus.trg;
    wr_en      = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.arm) begin
          pt_d    = bus.pretrig;
          cnt_d   = '0;
          state_d = (bus.pretrig == '0) ? ST_WAIT : ST_PRE;
        end
      end

      ST_PRE: begin
        wr_en = 1'b1;
        cnt_d = cnt_q + addr_t'(1);
        if (cnt_q == pt_q - addr_t'(1)) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        wr_en = 1'b1;
        if (trg_event) begin
          trg_addr_d = wp_q;
          // DEPTH-1-pt reduces to the bitwise complement of pt modulo DEPTH.
          cnt_d      = ~pt_q;
          state_d    = (pt_q == {DEPTH_LOG2{1'b1}}) ? ST_DONE : ST_POST;
        end
      end

      ST_POST: begin
        wr_en = 1'b1;
        cnt_d = cnt_q - addr_t'(1);
        if (cnt_q == addr_t'(1)) begin
          state_d = ST_DONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides everything, including a simultaneous arm or event; the
    // previous window bookkeeping stays intact.
    if (bus.abort) begin
      state_d    = ST_IDLE;
      wr_en      = 1'b0;
      cnt_d      = cnt_q;
      pt_d       = pt_q;
      trg_addr_d = trg_addr_q;
    end
  end

  assign wp_d = wr_en ? (wp_q + addr_t'(1)) : wp_q;

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wp_q       <= '0;
      cnt_q      <= '0;
      pt_q       <= '0;
      trg_addr_q <= '0;
      trg_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wp_q       <= wp_d;
      cnt_q      <= cnt_d;
      pt_q       <= pt_d;
      trg_addr_q <= trg_addr_d;
      trg_q      <= trg_d;
    end
  end

  // --------------------------------------------------------------------------
  // Sample RAM: write port from the capture FSM, synchronous read port for
  // the host. Logical index 0 maps to the oldest sample of the window.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wp_q] <= ain_dly;
    end
  end

  assign rd_phys = trg_addr_q - pt_q + bus.rd_addr;

  // Read data only updates while the window is frozen; otherwise it holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (state_q == ST_DONE) begin
      rd_data_q <= mem[rd_phys];
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.busy     = (state_q == ST_PRE) || (state_q == ST_WAIT) ||
                        (state_q == ST_POST);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.trg_addr = trg_addr_q;
  assign bus.rd_data  = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_trig_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_trig_capture
//  Description : Directed self-checking bench for trig_capture with a 16-deep
//                buffer and a 2-cycle alignment chain. The ADC input is a ramp
//                equal to the edge count, so every expected window sample is
//                derived from when the trigger was raised.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_trig_capture;

  localparam int DL    = 4;
  localparam int DEPTH = 1 << DL;
  localparam int ALN   = 2;

  logic clk;
  logic rst;

  trig_capture_if #(.DEPTH_LOG2(DL)) bus ();

  trig_capture #(
    .DEPTH_LOG2 (DL),
    .ALIGN      (ALN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  int edge_n   = 0;
  int wp_model = 0;
  int arm_edge, ev_edge, trg_val, cur_pt, exp_trg_addr;

  logic [13:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 ns later and the ramp advances.
  task automatic step();
    @(posedge clk);
    edge_n++;
    #1;
    bus.ain = 14'(edge_n);
  endtask

  task automatic arm_capture(input int pt);
    cur_pt      = pt;
    bus.pretrig = DL'(pt);
    bus.arm     = 1'b1;
    step();
    bus.arm  = 1'b0;
    arm_edge = edge_n;
    check("busy_after_arm", {31'd0, bus.busy}, 32'd1);
    check("done_after_arm", {31'd0, bus.done}, 32'd0);
  endtask

  // Raise trg for one sampled edge; the stored trigger sample is the ramp
  // value present ALIGN edges earlier.
  task automatic fire_trigger();
    bus.trg = 1'b1;
    trg_val = int'(bus.ain);
    step();
    ev_edge = edge_n;
    bus.trg = 1'b0;
    exp_trg_addr = (wp_model + ev_edge - arm_edge - 1) % DEPTH;
    check("trg_addr", {28'd0, bus.trg_addr}, 32'(exp_trg_addr));
  endtask

  task automatic wait_done();
    int c;
    c = DEPTH - 1 - cur_pt;
    if (c > 0) begin
      while (edge_n < ev_edge + c - 1) step();
      check("done_not_early", {31'd0, bus.done}, 32'd0);
      step();
    end
    check("done", {31'd0, bus.done}, 32'd1);
    check("busy_at_done", {31'd0, bus.busy}, 32'd0);
    wp_model = (wp_model + ev_edge - arm_edge + c) % DEPTH;
  endtask

  task automatic readout(input string tag);
    logic [13:0] e;
    for (int k = 0; k < DEPTH; k++) begin
      bus.rd_addr = DL'(k);
      exp_q.push_back(14'(trg_val - ALN - cur_pt + k));
      step();
      e = exp_q.pop_front();
      check(tag, {18'd0, bus.rd_data}, {18'd0, e});
    end
  endtask

  initial begin
    bus.ain     = '0;
    bus.trg     = 1'b0;
    bus.arm     = 1'b0;
    bus.abort   = 1'b0;
    bus.pretrig = '0;
    bus.rd_addr = '0;
    rst         = 1'b1;

    // Reset state
    repeat (3) step();
    check("rst_busy",     {31'd0, bus.busy},     32'd0);
    check("rst_done",     {31'd0, bus.done},     32'd0);
    check("rst_trg_addr", {28'd0, bus.trg_addr}, 32'd0);
    check("rst_rd_data",  {18'd0, bus.rd_data},  32'd0);
    rst = 1'b0;
    repeat (3) step();

    // Basic window: pretrig 5, trigger 20 cycles after arm
    arm_capture(5);
    repeat (20) step();
    fire_trigger();
    wait_done();
    readout("win_pt5");

    // pretrig 0, trigger on first WAIT cycle
    arm_capture(0);
    fire_trigger();
    wait_done();
    readout("win_pt0");

    // pretrig 15: done the cycle after the event
    arm_capture(15);
    repeat (15) step();
    fire_trigger();
    wait_done();
    readout("win_pt15");

    // Trigger pulse during PRE is ignored
    arm_capture(8);
    repeat (2) step();
    bus.trg = 1'b1;
    step();
    bus.trg = 1'b0;
    repeat (8) step();
    check("pre_pulse_busy",     {31'd0, bus.busy},     32'd1);
    check("pre_pulse_trg_addr", {28'd0, bus.trg_addr}, 32'(exp_trg_addr));
    fire_trigger();
    wait_done();
    readout("win_pt8");

    // trg held high across arm; extra edge during POST
    bus.trg = 1'b1;
    step();
    arm_capture(4);
    bus.trg = 1'b1;
    repeat (10) step();
    check("held_busy",     {31'd0, bus.busy},     32'd1);
    check("held_done",     {31'd0, bus.done},     32'd0);
    check("held_trg_addr", {28'd0, bus.trg_addr}, 32'(exp_trg_addr));
    bus.trg = 1'b0;
    step();
    fire_trigger();
    step();
    bus.trg = 1'b1;
    step();
    bus.trg = 1'b0;
    check("post_edge_trg_addr", {28'd0, bus.trg_addr}, 32'(exp_trg_addr));
    wait_done();
    readout("win_held");

    // Write pointer wraps several times while waiting
    arm_capture(3);
    repeat (50) step();
    fire_trigger();
    wait_done();
    readout("win_wrap");

    // Abort during POST, with a simultaneous arm that must lose
    arm_capture(2);
    repeat (3) step();
    fire_trigger();
    repeat (3) step();
    bus.abort = 1'b1;
    bus.arm   = 1'b1;
    step();
    bus.abort = 1'b0;
    bus.arm   = 1'b0;
    check("abort_busy",     {31'd0, bus.busy},     32'd0);
    check("abort_done",     {31'd0, bus.done},     32'd0);
    check("abort_trg_addr", {28'd0, bus.trg_addr}, 32'(exp_trg_addr));
    step();
    check("abort_idle_busy", {31'd0, bus.busy}, 32'd0);

    // Asynchronous reset during WAIT
    arm_capture(6);
    repeat (8) step();
    #2 rst = 1'b1;
    #1;
    check("arst_busy",     {31'd0, bus.busy},     32'd0);
    check("arst_done",     {31'd0, bus.done},     32'd0);
    check("arst_trg_addr", {28'd0, bus.trg_addr}, 32'd0);
    check("arst_rd_data",  {18'd0, bus.rd_data},  32'd0);
    #1 rst = 1'b0;
    wp_model = 0;
    repeat (3) step();

    // Clean capture after reset
    arm_capture(6);
    repeat (10) step();
    fire_trigger();
    wait_done();
    readout("win_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
